seq_add_sub: RTL
================

// Module: seq_add_sub
// PURPOSE
//   Multi-cycle, parametrised two's-complement adder/subtractor. Processes WIDTH-bit operands
//   CHUNK bits per cycle through a ripple chunk adder with a registered inter-chunk carry.
//   Successor to our 8-bit combinational add/sub: generic width, start/done handshake,
//   and carry/overflow/zero flags. Sits between the datapath register file and the result bus.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; must be a multiple of CHUNK
//   CHUNK  8   bits processed per cycle; NCHUNK = WIDTH/CHUNK (NCHUNK >= 1)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   start      in   1      request; sampled only when busy=0
//   sub        in   1      0: a+b, 1: a-b (sampled with start)
//   a          in   WIDTH  operand A (sampled with start)
//   b          in   WIDTH  operand B (sampled with start)
//   busy       out  1      high while an operation is in flight
//   done       out  1      one-cycle pulse when result/flags are valid
//   result     out  WIDTH  sum/difference; held until the next accepted start
//   carry_out  out  1      carry out of MSB (for subtraction: 1 = no borrow)
//   overflow   out  1      signed overflow
//   zero       out  1      result == 0
// BEHAVIOUR
//   - Reset: state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0.
//     Reset has priority over all other inputs; reset mid-operation aborts with no done pulse.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE --start--> RUN; RUN --(last chunk)--> DONE; DONE --start--> RUN; DONE --!start--> IDLE.
//   - Accept (start=1 in IDLE or DONE): latch a; latch b XOR {WIDTH{sub}}; carry register = sub;
//     chunk index = 0; busy=1 the next cycle. start while busy=1 is ignored (no queueing).
//   - RUN: each cycle adds chunk i of A, chunk i of B', and the carry register. Writes the CHUNK-bit sum
//     into result bits [i*CHUNK +: CHUNK]; the registered carry-out feeds chunk i+1.
//     The index does not wrap: after chunk NCHUNK-1 the FSM goes to DONE.
//   - Result bits are updated in place during RUN; they are valid only when done=1.
//   - Latency: start sampled at edge T -> done=1 during the cycle after edge T+NCHUNK.
//     Throughput is one operation per NCHUNK+1 cycles, including back-to-back starts from DONE.
//   - Flags are computed once, on the final chunk:
//       carry_out = carry from MSB
//       overflow  = carry into MSB XOR carry out of MSB
//       zero      = (final result == 0)
//     All flags are registered together with the last chunk and held with result.
//   - DONE: done=1 and busy=0 for exactly one cycle. Outputs hold until the next accept.
//   - Arithmetic is modulo 2^WIDTH. a-b is computed as a + ~b + 1, so b=0 with sub=1 gives carry_out=1.
// CONFIGURATION
//   - SEQ_ADD_SUB_SAT_EN defined: on signed overflow, result saturates.
//       Positive overflow (MSB of A == MSB of B' == 0) -> 0111..1; negative -> 1000..0.
//       overflow=1 is still reported, carry_out is unchanged, and zero is evaluated on the saturated value.
//       Saturation is applied in the final RUN cycle, so latency is unchanged.
//   - SEQ_ADD_SUB_SAT_EN undefined: result wraps modulo 2^WIDTH. No saturation logic is present.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//   1. Reset -> all outputs 0, busy=0. Then a=0x0000_00FF, b=0x0000_0001, sub=0:
//      done after 5 cycles; result=0x0000_0100, carry_out=0, overflow=0, zero=0.
//   2. a=0x0000_0005, b=0x0000_0005, sub=1 -> result=0, zero=1, carry_out=1, overflow=0.
//   3. a=0x7FFF_FFFF, b=1, sub=0 -> overflow=1; result=0x8000_0000 (wrap),
//      or 0x7FFF_FFFF with SEQ_ADD_SUB_SAT_EN.
//   4. a=0x8000_0000, b=1, sub=1 -> overflow=1; result=0x7FFF_FFFF,
//      or 0x8000_0000 with SEQ_ADD_SUB_SAT_EN.
//   5. start held high continuously: second op accepted in the DONE cycle; done pulses every 5 cycles;
//      a start pulse issued mid-RUN is dropped.
//   6. Assert rst during the third RUN cycle -> no done pulse, outputs 0 next cycle.
//      Repeat tests 1-5 with WIDTH=8, CHUNK=8 (done after 2 cycles) and WIDTH=16, CHUNK=4.

Source files
------------

// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle CHUNK-per-cycle add/sub with flags; SEQ_ADD_SUB_SAT_EN enables saturation
module seq_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, res_nxt, res_fin;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] ac, bc;
  logic [CHUNK:0] s;
  logic cy, accept, last, c_msb, ov;
  assign accept = start && state != RUN;
  assign last = idx == IW'(NCHUNK - 1);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  always_comb begin
    ac = '0;
    bc = '0;
    for (int k = 0; k < NCHUNK; k++)
      if (idx == IW'(k)) begin
        ac = a_r[k*CHUNK +: CHUNK];
        bc = b_r[k*CHUNK +: CHUNK];
      end
  end
  assign s = {1'b0, ac} + {1'b0, bc} + {{CHUNK{1'b0}}, cy};
  // carry into the MSB recovered from the sum bit; only meaningful on the last chunk
  assign c_msb = s[CHUNK-1] ^ ac[CHUNK-1] ^ bc[CHUNK-1];
  assign ov = c_msb ^ s[CHUNK];
  always_comb begin
    res_nxt = result;
    for (int k = 0; k < NCHUNK; k++)
      if (idx == IW'(k)) res_nxt[k*CHUNK +: CHUNK] = s[CHUNK-1:0];
  end
`ifdef SEQ_ADD_SUB_SAT_EN
  assign res_fin = ov ? (a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : res_nxt;
`else
  assign res_fin = res_nxt;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      cy <= 1'b0;
      idx <= '0;
      result <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b ^ {WIDTH{sub}};
      cy <= sub;
      idx <= '0;
    end else if (state == RUN) begin
      cy <= s[CHUNK];
      idx <= idx + 1'b1;
      result <= last ? res_fin : res_nxt;
      if (last) begin
        carry_out <= s[CHUNK];
        overflow <= ov;
        zero <= res_fin == '0;
      end
    end
endmodule
